// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and default widths for the systolic PE.
// The control FSM state enum lives here so the top and any future array
// wrapper agree on its encoding.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int CNT_W_DEF  = 8;

  // IDLE: no group open. ACCUM: a group has started and awaits its last fire.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_e;

endpackage

// File: rtl/systolic_pe_mult.sv
// systolic_pe_mult: stage 1 of the PE pipeline.
// Registers the full-width operand product together with a valid bit and a
// last-of-group bit. SIGNED selects two's-complement or unsigned operands.
module systolic_pe_mult
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                fire_i,
  input  logic                last_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] prod_o,
  output logic                prodValid_o,
  output logic                prodLast_o
);

  logic [2*DATA_W-1:0] aExt, bExt, prod_d, prod_q;
  logic                valid_q, last_q;

  // Extend both operands to the product width; the low 2*DATA_W bits of the product are then exact
  always_comb begin
    aExt = '0;
    bExt = '0;
    aExt[DATA_W-1:0] = a_i;
    bExt[DATA_W-1:0] = b_i;
    if (SIGNED != 0) begin
      for (int i = DATA_W; i < 2*DATA_W; i++) begin
        aExt[i] = a_i[DATA_W-1];
        bExt[i] = b_i[DATA_W-1];
      end
    end
    prod_d = aExt * bExt;
  end

  // Stage-1 register: a flush drops the valid bit so nothing reaches the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (fire_i) prod_q <= prod_d;
      valid_q <= fire_i & ~flush_i;
      last_q  <= fire_i & ~flush_i & last_i;
    end
  end

  assign prod_o      = prod_q;
  assign prodValid_o = valid_q;
  assign prodLast_o  = last_q;

endmodule

// File: rtl/systolic_pe.sv
// systolic_pe: one multiply-accumulate processing element of a systolic array.
// Operands are forwarded to neighbours one cycle later; products of a group of
// k_len fires are summed and presented on acc_out with a one-cycle acc_valid.
// Optional macro SYSTOLIC_PE_SAT_EN: clamp overflowing accumulates instead of
// wrapping (ovf is set in either build).
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [CNT_W-1:0]  k_len,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              a_valid_in,
  input  logic              b_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              a_valid_out,
  output logic              b_valid_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              busy,
  output logic              ovf
);

  pe_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, len_q, len_d, effLen, cntInc;
  logic                fire, lastFire;
  logic [2*DATA_W-1:0] prod;
  logic                prodValid, prodLast;
  logic [ACC_W-1:0]    acc_q, prodExt, accSum, accOut_q;
  logic [ACC_W:0]      sumWide;
  logic                accOvf, accValid_q, ovf_q;
  logic [DATA_W-1:0]   aPass_q, bPass_q;
  logic                aValidPass_q, bValidPass_q;

  assign fire   = a_valid_in & b_valid_in & ~clear;
  assign effLen = (k_len == '0) ? CNT_W'(1) : k_len;
  assign cntInc = cnt_q + CNT_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a group opens on a non-final first fire and closes on its last fire
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (fire) begin
      case (state_q)
        IDLE:    if (!lastFire) state_d = ACCUM;
        ACCUM:   if (lastFire)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: busy, last-fire detection and group length/count bookkeeping
  always_comb begin
    busy     = (state_q == ACCUM);
    lastFire = 1'b0;
    cnt_d    = cnt_q;
    len_d    = len_q;
    if (clear) begin
      cnt_d = '0;
    end else if (fire) begin
      if (state_q == IDLE) begin
        len_d    = effLen;
        lastFire = (effLen == CNT_W'(1));
        cnt_d    = lastFire ? '0 : CNT_W'(1);
      end else begin
        lastFire = (cntInc == len_q);
        cnt_d    = lastFire ? '0 : cntInc;
      end
    end
  end

  // Group counter and the length sampled on the first fire of each group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  systolic_pe_mult #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (clear),
    .fire_i      (fire),
    .last_i      (lastFire),
    .a_i         (a_in),
    .b_i         (b_in),
    .prod_o      (prod),
    .prodValid_o (prodValid),
    .prodLast_o  (prodLast)
  );

  // Extend the product, add it with one guard bit, detect overflow and optionally clamp
  always_comb begin
    prodExt = '0;
    prodExt[2*DATA_W-1:0] = prod;
    if (SIGNED != 0) begin
      for (int i = 2*DATA_W; i < ACC_W; i++) prodExt[i] = prod[2*DATA_W-1];
      sumWide = {acc_q[ACC_W-1], acc_q} + {prodExt[ACC_W-1], prodExt};
      accOvf  = sumWide[ACC_W] ^ sumWide[ACC_W-1];
    end else begin
      sumWide = {1'b0, acc_q} + {1'b0, prodExt};
      accOvf  = sumWide[ACC_W];
    end
    accSum = sumWide[ACC_W-1:0];
`ifdef SYSTOLIC_PE_SAT_EN
    if (accOvf) begin
      if (SIGNED != 0)
        accSum = sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        accSum = '1;
    end
`endif
  end

  // Stage 2: accumulate, publish the result on the last product, clear wins over everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      accOut_q   <= '0;
      accValid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      accValid_q <= 1'b0;
      if (clear) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (prodValid) begin
        if (accOvf) ovf_q <= 1'b1;
        if (prodLast) begin
          accOut_q   <= accSum;
          accValid_q <= 1'b1;
          acc_q      <= '0;
        end else begin
          acc_q <= accSum;
        end
      end
    end
  end

  // Operand and qualifier forwarding to neighbouring PEs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aPass_q      <= '0;
      bPass_q      <= '0;
      aValidPass_q <= 1'b0;
      bValidPass_q <= 1'b0;
    end else begin
      aPass_q      <= a_in;
      bPass_q      <= b_in;
      aValidPass_q <= a_valid_in;
      bValidPass_q <= b_valid_in;
    end
  end

  assign a_out       = aPass_q;
  assign b_out       = bPass_q;
  assign a_valid_out = aValidPass_q;
  assign b_valid_out = bValidPass_q;
  assign acc_out     = accOut_q;
  assign acc_valid   = accValid_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// tb_systolic_pe: scoreboard bench for systolic_pe.
// Two PEs share one stimulus stream: index 0 is unsigned, index 1 signed, both
// with a 16-bit accumulator so overflow is reachable. A driver issues stimulus
// on the falling edge and keeps a group-level arithmetic model; a monitor
// checks every output shortly after each rising edge.
module tb_systolic_pe;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int CW = 8;

  logic          clk, rst_n, clear;
  logic [CW-1:0] k_len;
  logic [DW-1:0] a_in, b_in;
  logic          a_valid_in, b_valid_in;

  logic [DW-1:0] aOutU, bOutU, aOutS, bOutS;
  logic          avOutU, bvOutU, avOutS, bvOutS;
  logic [AW-1:0] accOutU, accOutS;
  logic          accValidU, accValidS, busyU, busyS, ovfU, ovfS;

  typedef struct {
    logic [AW-1:0] val;
    int            edgeNo;
  } exp_t;

  exp_t qU[$];
  exp_t qS[$];

  int nChecks = 0;
  int nFails  = 0;
  int edgeCnt = 0;

  // Behavioural model state
  longint        accM[2];
  bit            ovfM[2];
  longint        pendP[2];
  bit            pendValid, pendLast, groupOpen;
  int            lenM, cntM;
  logic [DW-1:0] expA, expB;
  bit            expAv, expBv;
  logic [AW-1:0] accOutExp[2];

  systolic_pe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SIGNED(0)) dutU (
    .clk(clk), .rst_n(rst_n), .clear(clear), .k_len(k_len),
    .a_in(a_in), .b_in(b_in), .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
    .a_out(aOutU), .b_out(bOutU), .a_valid_out(avOutU), .b_valid_out(bvOutU),
    .acc_out(accOutU), .acc_valid(accValidU), .busy(busyU), .ovf(ovfU)
  );

  systolic_pe #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .SIGNED(1)) dutS (
    .clk(clk), .rst_n(rst_n), .clear(clear), .k_len(k_len),
    .a_in(a_in), .b_in(b_in), .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
    .a_out(aOutS), .b_out(bOutS), .a_valid_out(avOutS), .b_valid_out(bvOutS),
    .acc_out(accOutS), .acc_valid(accValidS), .busy(busyS), .ovf(ovfS)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", nm, edgeCnt, act, exp);
    end
  endtask

  // Add one product to a model accumulator with range check and wrap or clamp
  function automatic void stepAcc(input int d, input longint p);
    longint s, lo, hi;
    s = accM[d] + p;
    if (d == 1) begin
      lo = -(longint'(1) << (AW-1));
      hi = (longint'(1) << (AW-1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << AW) - 1;
    end
    if (s < lo || s > hi) begin
      ovfM[d] = 1'b1;
`ifdef SYSTOLIC_PE_SAT_EN
      s = (s < lo) ? lo : hi;
`else
      s = s & ((longint'(1) << AW) - 1);
      if (d == 1 && s > hi) s = s - (longint'(1) << AW);
`endif
    end
    accM[d] = s;
  endfunction

  function automatic void pushExp(input int d);
    exp_t e;
    longint v;
    v = accM[d];
    e.val    = v[AW-1:0];
    e.edgeNo = edgeCnt + 1;
    if (d == 0) qU.push_back(e);
    else        qS.push_back(e);
  endfunction

  function automatic void resetModel();
    for (int d = 0; d < 2; d++) begin
      accM[d]      = 0;
      ovfM[d]      = 1'b0;
      pendP[d]     = 0;
      accOutExp[d] = '0;
    end
    pendValid = 1'b0;
    pendLast  = 1'b0;
    groupOpen = 1'b0;
    lenM      = 0;
    cntM      = 0;
    expA      = '0;
    expB      = '0;
    expAv     = 1'b0;
    expBv     = 1'b0;
    qU.delete();
    qS.delete();
  endfunction

  // Model the effect of the upcoming rising edge given the inputs now driven
  function automatic void modelEdge(input bit clr, input bit fire);
    bit last;
    if (pendValid && !clr) begin
      for (int d = 0; d < 2; d++) begin
        stepAcc(d, pendP[d]);
        if (pendLast) begin
          pushExp(d);
          accM[d] = 0;
        end
      end
    end
    pendValid = 1'b0;
    if (clr) begin
      accM[0]   = 0;
      accM[1]   = 0;
      ovfM[0]   = 1'b0;
      ovfM[1]   = 1'b0;
      groupOpen = 1'b0;
    end else if (fire) begin
      if (!groupOpen) begin
        lenM = (k_len == 0) ? 1 : int'(k_len);
        cntM = 0;
      end
      cntM++;
      last      = (cntM == lenM);
      groupOpen = !last;
      pendValid = 1'b1;
      pendLast  = last;
      pendP[0]  = longint'(a_in) * longint'(b_in);
      pendP[1]  = longint'($signed(a_in)) * longint'($signed(b_in));
    end
  endfunction

  task automatic applyStimulus(input bit rst, input bit clr, input bit av, input bit bv,
                               input int k, input int a, input int b);
    @(negedge clk);
    rst_n      = rst;
    clear      = clr;
    a_valid_in = av;
    b_valid_in = bv;
    k_len      = CW'(k);
    a_in       = DW'(a);
    b_in       = DW'(b);
    if (!rst) begin
      resetModel();
    end else begin
      expA  = a_in;
      expB  = b_in;
      expAv = av;
      expBv = bv;
      modelEdge(clr, av && bv && !clr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Pull reset low between edges and confirm every output drops immediately
  task automatic assertAsyncReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_a_out_U",   32'(aOutU), 32'(0));
    checkOutput("rst_a_vout_S",  32'(avOutS), 32'(0));
    checkOutput("rst_acc_out_U", 32'(accOutU), 32'(0));
    checkOutput("rst_acc_out_S", 32'(accOutS), 32'(0));
    checkOutput("rst_busy_U",    32'(busyU), 32'(0));
    checkOutput("rst_ovf_U",     32'(ovfU), 32'(0));
    checkOutput("rst_valid_S",   32'(accValidS), 32'(0));
    resetModel();
  endtask

  task automatic checkStrobe(input int d, input logic v, input logic [AW-1:0] act);
    exp_t  e;
    bit    have;
    string tag;
    tag  = (d == 0) ? "U" : "S";
    have = 1'b0;
    if (d == 0 && qU.size() > 0) begin
      have = 1'b1;
      e    = qU[0];
    end else if (d == 1 && qS.size() > 0) begin
      have = 1'b1;
      e    = qS[0];
    end
    if (v) begin
      checkOutput({"strobe_expected_", tag}, 32'(have), 32'(1));
      if (have) begin
        if (d == 0) void'(qU.pop_front());
        else        void'(qS.pop_front());
        checkOutput({"acc_out_", tag}, 32'(act), 32'(e.val));
        checkOutput({"strobe_edge_", tag}, 32'(edgeCnt), 32'(e.edgeNo));
        accOutExp[d] = e.val;
      end
    end else begin
      if (have && e.edgeNo <= edgeCnt) begin
        checkOutput({"strobe_present_", tag}, 32'(v), 32'(1));
        if (d == 0) void'(qU.pop_front());
        else        void'(qS.pop_front());
      end
      checkOutput({"acc_hold_", tag}, 32'(act), 32'(accOutExp[d]));
    end
  endtask

  // Monitor: samples two time units after every rising edge
  initial begin
    forever begin
      @(posedge clk);
      edgeCnt++;
      #2;
      checkOutput("a_out_U",  32'(aOutU),  32'(expA));
      checkOutput("b_out_U",  32'(bOutU),  32'(expB));
      checkOutput("a_vout_U", 32'(avOutU), 32'(expAv));
      checkOutput("b_vout_U", 32'(bvOutU), 32'(expBv));
      checkOutput("a_out_S",  32'(aOutS),  32'(expA));
      checkOutput("b_vout_S", 32'(bvOutS), 32'(expBv));
      checkOutput("busy_U",   32'(busyU),  32'(groupOpen));
      checkOutput("busy_S",   32'(busyS),  32'(groupOpen));
      checkOutput("ovf_U",    32'(ovfU),   32'(ovfM[0]));
      checkOutput("ovf_S",    32'(ovfS),   32'(ovfM[1]));
      checkStrobe(0, accValidU, accOutU);
      checkStrobe(1, accValidS, accOutS);
    end
  end

  // Driver: directed scenarios followed by a randomized stream
  initial begin
    int a, b;
    rst_n      = 1'b0;
    clear      = 1'b0;
    k_len      = '0;
    a_in       = '0;
    b_in       = '0;
    a_valid_in = 1'b0;
    b_valid_in = 1'b0;
    resetModel();

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("[TB] four-product unsigned group");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4, i + 1, i + 5);
    idle(4);

    $display("[TB] back-to-back groups of two");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2, 3, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2, 3, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2, 10, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2, 10, 1);
    idle(4);

    $display("[TB] signed operands, k_len changing mid-group");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3, -2, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 7, 4, -3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1, -1, -7);
    idle(4);

    $display("[TB] clear together with a fire");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3, 9, 9);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3, 7, 7);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3, 1, 1);
    idle(4);

    $display("[TB] overflow and k_len of zero");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2, 255, 255);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2, 255, 255);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 6, 7);
    idle(4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(2);

    $display("[TB] reset in the middle of a group");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4, 'h5a, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4, 'h5a, 3);
    assertAsyncReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, i[0], 1'b1, 4, 'h33, 'h44);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1, 2, 3);
    idle(4);

    $display("[TB] randomized stream");
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      applyStimulus(1'b1, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0), int'($urandom_range(0, 5)), a, b);
    end
    idle(6);

    checkOutput("scoreboard_drained_U", 32'(qU.size()), 32'(0));
    checkOutput("scoreboard_drained_S", 32'(qS.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
